data_ram: RTL and testbench

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram_pkg.sv | 28 ++
 rtl/data_ram_align.sv | 45 ++++
 rtl/data_ram.sv | 186 ++++++++++++++++++
 tb/tb_data_ram.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared size encodings, default geometry and FSM state type for data_ram.
// Defining DATA_RAM_ZERO_INIT_EN adds the INIT (array clearing) state.
package data_ram_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 1024;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

`ifdef DATA_RAM_ZERO_INIT_EN
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;
  localparam state_e ST_RESET = ST_INIT;
`else
  typedef enum logic {
    ST_IDLE = 1'b1
  } state_e;
  localparam state_e ST_RESET = ST_IDLE;
`endif

endpackage

// File: rtl/data_ram_align.sv
// Load alignment: moves the addressed lanes of a memory word down to bit 0
// and sign- or zero-extends the result to the full word width.
module data_ram_align
  import data_ram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]           word_i,
  input  logic [$clog2(WIDTH/8)-1:0] off_i,
  input  size_e                      size_i,
  input  logic                       unsigned_i,
  output logic [WIDTH-1:0]           data_o
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] keep;
  logic             sign;

  // keep marks the bits that belong to the access; everything above is extension
  always_comb begin
    shifted = word_i >> {off_i, 3'b000};
    keep    = '1;
    sign    = shifted[WIDTH-1];
    unique case (size_i)
      SIZE_B: begin
        keep = WIDTH'(8'hFF);
        sign = shifted[7];
      end
      SIZE_H: begin
        keep = WIDTH'(16'hFFFF);
        sign = shifted[15];
      end
      SIZE_W: begin
        keep = WIDTH'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
      default: begin
        keep = '1;
        sign = shifted[WIDTH-1];
      end
    endcase
    data_o = (shifted & keep) | ({WIDTH{sign & ~unsigned_i}} & ~keep);
  end

endmodule

// File: rtl/data_ram.sv
// Byte-addressable single-port data RAM with sized, aligned loads/stores.
// Define DATA_RAM_ZERO_INIT_EN to clear the array after reset before serving.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int LANES   = WIDTH / 8;
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int OFF_W   = $clog2(LANES);
  localparam int ADDR_HI = IDX_W + OFF_W;

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic             ld_q, ld_d;
  size_e            size_q, size_d;
  logic             uns_q, uns_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [WIDTH-1:0] hold_q, hold_d;
`ifdef DATA_RAM_ZERO_INIT_EN
  logic [IDX_W-1:0] clr_q, clr_d;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_word_q;

  size_e            req_sz;
  logic             accept;
  logic             range_err, size_err, align_err, req_err;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic [2:0]       align_mask;
  logic [7:0]       be_base;
  logic [LANES-1:0] req_be;
  logic [WIDTH-1:0] req_wdata_sh;

  logic             mem_we;
  logic             rd_en;
  logic [IDX_W-1:0] mem_idx;
  logic [LANES-1:0] mem_be;
  logic [WIDTH-1:0] mem_wdata;

  logic [WIDTH-1:0] ld_data, rsp_data;

  // Request decode: word index, lane enables and the three error sources
  always_comb begin
    req_sz       = size_e'(req_size);
    accept       = req_valid && ready_q;
    req_idx      = req_addr[ADDR_HI-1:OFF_W];
    req_off      = req_addr[OFF_W-1:0];
    range_err    = |(req_addr >> ADDR_HI);
    size_err     = (req_sz == SIZE_D) && (WIDTH < 64);
    align_mask   = 3'b000;
    be_base      = 8'h01;
    unique case (req_sz)
      SIZE_B: begin align_mask = 3'b000; be_base = 8'h01; end
      SIZE_H: begin align_mask = 3'b001; be_base = 8'h03; end
      SIZE_W: begin align_mask = 3'b011; be_base = 8'h0F; end
      default: begin align_mask = 3'b111; be_base = 8'hFF; end
    endcase
    align_err    = |(req_addr[2:0] & align_mask);
    req_err      = range_err | size_err | align_err;
    req_be       = be_base[LANES-1:0] << req_off;
    req_wdata_sh = req_wdata << {req_off, 3'b000};
  end

  // The clear sweep owns the write port while in INIT
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    rd_en     = 1'b0;
    mem_idx   = req_idx;
    mem_be    = req_be;
    mem_wdata = req_wdata_sh;
`ifdef DATA_RAM_ZERO_INIT_EN
    clr_d     = clr_q;
`endif
    case (state_q)
`ifdef DATA_RAM_ZERO_INIT_EN
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_idx   = clr_q;
        mem_be    = '1;
        mem_wdata = '0;
        clr_d     = clr_q + 1'b1;
        if (clr_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        mem_we = accept && req_we && !req_err;
        rd_en  = accept && !req_we && !req_err;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Response path; rsp_rdata keeps the last response value between pulses
  always_comb begin
    rsp_valid_d = accept;
    rsp_err_d   = accept && req_err;
    ld_d        = accept && !req_we && !req_err;
    size_d      = req_sz;
    uns_d       = req_unsigned;
    off_d       = req_off;
    rsp_data    = ld_q ? ld_data : '0;
    hold_d      = rsp_valid_q ? rsp_data : hold_q;
  end

  data_ram_align #(
    .WIDTH (WIDTH)
  ) u_align (
    .word_i     (rd_word_q),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data)
  );

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (mem_be[l]) begin
          mem[mem_idx][l*8 +: 8] <= mem_wdata[l*8 +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_word_q <= mem[req_idx];
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RESET;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      ld_q        <= 1'b0;
      size_q      <= SIZE_B;
      uns_q       <= 1'b0;
      off_q       <= '0;
      hold_q      <= '0;
`ifdef DATA_RAM_ZERO_INIT_EN
      clr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      ld_q        <= ld_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      hold_q      <= hold_d;
`ifdef DATA_RAM_ZERO_INIT_EN
      clr_q       <= clr_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_valid_q ? rsp_data : hold_q;

endmodule

// File: tb/tb_data_ram.sv
// Testbench for data_ram: directed vectors plus random traffic against a
// byte-array reference model. Build with DATA_RAM_ZERO_INIT_EN for the INIT checks.
module tb_data_ram;
  import data_ram_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int BYTES = DEPTH * 4;

  logic             CLK;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  refMem [BYTES];
  logic        expValid;
  logic        expErr;
  logic [31:0] expData;
  logic [31:0] lastData;

  data_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte-level memory: a store writes n bytes little-endian, a load gathers them
  task automatic modelAccess(input logic we, input logic [1:0] sz, input logic un,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic err, output logic [31:0] data);
    int unsigned n;
    n    = 1 << sz;
    err  = (sz == 2'd3) || (a >= BYTES) || ((a % n) != 0);
    data = 32'd0;
    if (!err && we) begin
      for (int i = 0; i < int'(n); i++) refMem[a + i] = wd[8*i +: 8];
    end else if (!err) begin
      for (int i = 0; i < int'(n); i++) data[8*i +: 8] = refMem[a + i];
      if (!un && n < 4 && data[8*n - 1]) data = data | ~((32'd1 << (8*n)) - 32'd1);
    end
  endtask

  task automatic checkOutput();
    checkVal("rsp_valid", rsp_valid, expValid);
    checkVal("rsp_err", rsp_err, expValid & expErr);
    if (expValid) begin
      checkVal("rsp_rdata", rsp_rdata, expData);
      lastData = expData;
    end else begin
      checkVal("rsp_hold", rsp_rdata, lastData);
    end
  endtask

  // Called on a negedge: checks the previous response, drives one request slot
  task automatic applyStimulus(input logic v, input logic we, input logic [1:0] sz,
                               input logic un, input logic [31:0] a, input logic [31:0] wd);
    logic        err;
    logic [31:0] data;
    checkOutput();
    checkVal("req_ready", req_ready, 1'b1);
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = wd;
    expValid     = v;
    expErr       = 1'b0;
    expData      = 32'd0;
    if (v) begin
      modelAccess(we, sz, un, a, wd, err, data);
      expErr  = err;
      expData = data;
    end
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic expectRsp(input string tag, input logic [31:0] data, input logic err);
    checkVal(tag, rsp_rdata, data);
    checkVal({tag, "_err"}, rsp_err, err);
  endtask

  task automatic releaseAndCount(input string tag);
    int cycles;
    cycles = 0;
    reset  = 1'b1;
    while (req_ready !== 1'b1 && cycles < DEPTH + 16) begin
      @(negedge CLK);
      cycles++;
    end
    checkVal(tag, cycles, DEPTH);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;

    reset        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = '0;
    expValid     = 1'b0;
    expErr       = 1'b0;
    expData      = 32'd0;
    lastData     = 32'd0;
    for (int i = 0; i < BYTES; i++) refMem[i] = 8'h00;

    repeat (3) @(negedge CLK);
    checkVal("rst_ready", req_ready, 1'b0);
    checkVal("rst_rsp_valid", rsp_valid, 1'b0);
    checkVal("rst_rsp_err", rsp_err, 1'b0);
    checkVal("rst_rsp_rdata", rsp_rdata, 32'd0);

`ifdef DATA_RAM_ZERO_INIT_EN
    releaseAndCount("init_len");
    applyStimulus(1'b1, 1'b0, SIZE_W, 1'b0, 32'h10, 32'd0);
    expectRsp("lw_0x10", 32'h0000_0000, 1'b0);
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    repeat (5) @(negedge CLK);
    reset = 1'b0;
    #1;
    checkVal("midclr_ready", req_ready, 1'b0);
    @(negedge CLK);
    expValid = 1'b0;
    lastData = 32'd0;
    releaseAndCount("reinit_len");
`else
    reset = 1'b1;
    #1;
    checkVal("pre_edge_ready", req_ready, 1'b0);
    @(negedge CLK);
    checkVal("first_edge_ready", req_ready, 1'b1);
    applyStimulus(1'b1, 1'b1, SIZE_W, 1'b0, 32'h4, 32'h1);
    applyStimulus(1'b1, 1'b0, SIZE_W, 1'b0, 32'h4, 32'd0);
    expectRsp("lw_0x4", 32'h0000_0001, 1'b0);
`endif

    $display("[TB] directed load/store vectors");
    applyStimulus(1'b1, 1'b1, SIZE_W, 1'b0, 32'h0, 32'h1122_3344);
    applyStimulus(1'b1, 1'b1, SIZE_W, 1'b0, 32'h8, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, SIZE_B, 1'b0, 32'h9, 32'd0);
    expectRsp("lb_0x9", 32'hFFFF_FFBE, 1'b0);
    applyStimulus(1'b1, 1'b0, SIZE_B, 1'b1, 32'h9, 32'd0);
    expectRsp("lbu_0x9", 32'h0000_00BE, 1'b0);
    applyStimulus(1'b1, 1'b0, SIZE_H, 1'b0, 32'hA, 32'd0);
    expectRsp("lh_0xa", 32'hFFFF_DEAD, 1'b0);
    applyStimulus(1'b1, 1'b1, SIZE_B, 1'b0, 32'hB, 32'h55);
    expectRsp("sb_rdata", 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, SIZE_W, 1'b0, 32'h8, 32'd0);
    expectRsp("raw_lw_0x8", 32'h55AD_BEEF, 1'b0);
    applyStimulus(1'b1, 1'b0, SIZE_W, 1'b0, 32'h6, 32'd0);
    expectRsp("lw_mis_0x6", 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, SIZE_H, 1'b0, 32'h3, 32'h1234);
    expectRsp("sh_mis_0x3", 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, SIZE_W, 1'b0, 32'h0, 32'd0);
    expectRsp("lw_0x0", 32'h1122_3344, 1'b0);
    applyStimulus(1'b1, 1'b0, SIZE_D, 1'b0, 32'h0, 32'd0);
    expectRsp("ld_w32", 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, SIZE_W, 1'b0, 32'(BYTES), 32'd0);
    expectRsp("lw_oor", 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, SIZE_W, 1'b0, 32'h8, 32'd0);
    applyStimulus(1'b0, 1'b0, SIZE_W, 1'b0, 32'h0, 32'd0);
    applyStimulus(1'b0, 1'b0, SIZE_W, 1'b0, 32'h0, 32'd0);
    expectRsp("idle_hold", 32'h55AD_BEEF, 1'b0);

    $display("[TB] random traffic");
    for (int w = 0; w < 16; w++) begin
      applyStimulus(1'b1, 1'b1, SIZE_W, 1'b0, 32'(w * 4), $urandom);
    end
    for (int n = 0; n < 1500; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0) a = $urandom | 32'(BYTES);
      applyStimulus($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), sz,
                    1'($urandom_range(0, 1)), a, $urandom);
    end

    applyStimulus(1'b1, 1'b0, SIZE_W, 1'b0, 32'h8, 32'd0);
    reset = 1'b0;
    #1;
    checkVal("drop_rsp_valid", rsp_valid, 1'b0);
    checkVal("drop_rsp_rdata", rsp_rdata, 32'd0);
    checkVal("drop_rsp_err", rsp_err, 1'b0);
    checkVal("drop_ready", req_ready, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
